// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles framed bytes into 32-bit words, writes
// them to progmem, and releases the core only after opcode and checksum checks.
module prog_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          MAX_OPCODE = 18,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {SYNC, CNT_LO, CNT_HI, DATA, WRITE, CHK, DONE, ERR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                state;
  logic [15:0]           n_words;
  logic [23:0]           shift;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            csum;

  logic        take;
  logic [31:0] full_word;
  logic [15:0] n_hi;
  logic        op_legal;
  logic        last_word;

  assign in_ready  = (state == SYNC) || (state == CNT_LO) || (state == CNT_HI) ||
                     (state == DATA) || (state == CHK);
  assign take      = in_valid & in_ready;
  assign full_word = {in_byte, shift};
  assign n_hi      = {in_byte, n_words[7:0]};
  assign op_legal  = (full_word[31:27] != 5'd0) && (full_word[31:27] <= 5'(MAX_OPCODE));
  assign last_word = (16'(word_idx) == n_words - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      n_words      <= '0;
      shift        <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      err_code     <= 2'd0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        SYNC:   if (take && in_byte == SYNC_BYTE) state <= CNT_LO;
        CNT_LO: if (take) begin
          n_words[7:0] <= in_byte;
          state        <= CNT_HI;
        end
        CNT_HI: if (take) begin
          n_words <= n_hi;
          if ({1'b0, n_hi} > MAX_WORDS) begin
            state      <= ERR;
            load_error <= 1'b1;
            err_code   <= 2'd1;
          end else if (n_hi == 16'd0) begin
            state <= CHK;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (take) begin
          csum     <= csum ^ in_byte;
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Strobe lands in the WRITE cycle; an illegal word just leaves
            // mem_we low and WRITE routes to ERR.
            state <= WRITE;
            if (op_legal) begin
              mem_we       <= 1'b1;
              mem_addr     <= word_idx;
              mem_wdata    <= full_word;
              words_loaded <= words_loaded + 1'b1;
            end
          end else begin
            shift <= {in_byte, shift[23:8]};
          end
        end
        WRITE: begin
          if (!mem_we) begin
            state      <= ERR;
            load_error <= 1'b1;
            err_code   <= 2'd2;
          end else if (last_word) begin
            state <= CHK;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= DATA;
          end
        end
        CHK: if (take) begin
          if (in_byte == csum) begin
            state     <= DONE;
            load_done <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state      <= ERR;
            load_error <= 1'b1;
            err_code   <= 2'd3;
          end
        end
        DONE:    ;
        ERR:     ;
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as frames are
// built and matched against mem_we pulses; status flags are checked per scenario.
module tb_prog_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  int vectors     = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];   // {addr padded to 8 bits, data}
  logic [7:0]  fq[$];      // frame bytes to send

  prog_loader #(.ADDR_WIDTH(AW), .MAX_OPCODE(18), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_error(load_error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      logic [39:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %h, want addr %0d data %h",
                   mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    in_byte = b; in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: in_ready %b, want 1 for byte %h", in_ready, b);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_prefix(input int count, input bit gap);
    for (int i = 0; i < count; i++) send_byte(fq[i], gap);
  endtask

  // Builds a full frame in fq and queues expected writes for legal words.
  task automatic build_frame(input int n, input logic [31:0] w[$], input logic [7:0] chk_flip);
    logic [7:0] x = 8'h00;
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(n[7:0]);
    fq.push_back(n[15:8]);
    for (int i = 0; i < w.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        fq.push_back(w[i][8*k +: 8]);
        x ^= w[i][8*k +: 8];
      end
      if (w[i][31:27] >= 5'd1 && w[i][31:27] <= 5'd18)
        exp_q.push_back({8'(i), w[i]});
    end
    fq.push_back(x ^ chk_flip);
  endtask

  task automatic check_status(input string name, input logic done, input logic err,
                              input logic [1:0] code, input logic hold, input int wl);
    vectors++;
    if ({load_done, load_error, err_code, core_hold} !== {done, err, code, hold} ||
        words_loaded !== (AW+1)'(wl)) begin
      miscompares++;
      $display("FAIL %s: got done %b err %b code %0d hold %b words %0d, want done %b err %b code %0d hold %b words %0d",
               name, load_done, load_error, err_code, core_hold, words_loaded,
               done, err, code, hold, wl);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d writes outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_status("reset_flags", 0, 0, 2'd0, 1, 0);
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mem: got we %b addr %0d data %h rdy %b, want 0 0 0 1",
               mem_we, mem_addr, mem_wdata, in_ready);
    end
  endtask

  task automatic test_two_words();
    logic [31:0] w[$] = '{32'h0A0C0401, 32'h90000003};
    do_reset();
    build_frame(2, w, 8'h00);
    send_prefix(fq.size(), 1'b0);
    wait_cycles(2);
    check_status("two_words", 1, 0, 2'd0, 0, 2);
    check_drained("two_words_writes");
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ready: got %b, want 0", in_ready);
    end
  endtask

  task automatic test_garbage();
    logic [31:0] w[$] = '{32'h4123_5678};
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    build_frame(1, w, 8'h00);
    send_prefix(fq.size(), 1'b0);
    wait_cycles(2);
    check_status("garbage", 1, 0, 2'd0, 0, 1);
    check_drained("garbage_writes");
  endtask

  task automatic test_bad_opcode();
    logic [31:0] w[$] = '{32'h0000_0000};
    do_reset();
    build_frame(1, w, 8'h00);
    send_prefix(7, 1'b0);
    wait_cycles(3);
    check_status("bad_opcode", 0, 1, 2'd2, 1, 0);
    check_drained("bad_opcode_writes");
  endtask

  task automatic test_opcode_19();
    logic [31:0] w[$] = '{32'h0800_0001, {5'd19, 27'h1}};
    do_reset();
    build_frame(2, w, 8'h00);
    send_prefix(11, 1'b0);
    wait_cycles(3);
    check_status("opcode_19", 0, 1, 2'd2, 1, 1);
    check_drained("opcode_19_writes");
  endtask

  task automatic test_bad_checksum();
    logic [31:0] w[$] = '{32'h1234_ABCD};
    do_reset();
    build_frame(1, w, 8'h01);
    send_prefix(fq.size(), 1'b0);
    wait_cycles(2);
    check_status("bad_checksum", 0, 1, 2'd3, 1, 1);
    check_drained("bad_checksum_writes");
  endtask

  task automatic test_size();
    logic [31:0] w[$];
    do_reset();
    build_frame(257, w, 8'h00);
    send_prefix(3, 1'b0);
    @(negedge clk);
    check_status("size_257", 0, 1, 2'd1, 1, 0);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL err_ready: got %b, want 0", in_ready);
    end
  endtask

  task automatic test_zero();
    logic [31:0] w[$];
    do_reset();
    build_frame(0, w, 8'h00);
    send_prefix(fq.size(), 1'b0);
    wait_cycles(2);
    check_status("zero_words", 1, 0, 2'd0, 0, 0);
  endtask

  task automatic test_rst_mid_frame();
    logic [31:0] w[$] = '{32'h8877_6655};
    do_reset();
    fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_prefix(5, 1'b0);
    do_reset();
    check_status("mid_rst", 0, 0, 2'd0, 1, 0);
    build_frame(1, w, 8'h00);
    send_prefix(fq.size(), 1'b1);
    wait_cycles(2);
    check_status("reload_gapped", 1, 0, 2'd0, 0, 1);
    check_drained("reload_writes");
  endtask

  task automatic test_full_image();
    logic [31:0] w[$];
    for (int i = 0; i < 256; i++)
      w.push_back({5'((i % 18) + 1), 27'($urandom)});
    do_reset();
    build_frame(256, w, 8'h00);
    send_prefix(fq.size(), 1'b0);
    wait_cycles(2);
    check_status("full_256", 1, 0, 2'd0, 0, 256);
    check_drained("full_256_writes");
    vectors++;
    if (mem_addr !== 8'd255) begin
      miscompares++;
      $display("FAIL last_addr: got %0d, want 255", mem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    test_reset();
    test_two_words();
    test_garbage();
    test_bad_opcode();
    test_opcode_19();
    test_bad_checksum();
    test_size();
    test_zero();
    test_rst_mid_frame();
    test_full_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader for the mini microcontroller.
- It is the writing end of instruction memory: it receives a framed byte stream, assembles 32-bit instruction words, and writes them into progmem at incrementing addresses.
- It holds the core in reset until the image loads cleanly.
- It checks opcode legality and a frame checksum before releasing the core.

Parameters:
- ADDR_WIDTH, 8, progmem word-address width; max image size is 2**ADDR_WIDTH words.
- MAX_OPCODE, 18, highest legal opcode value; legal range is 1..MAX_OPCODE.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_byte  in  8  stream data byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid & in_ready at posedge clk
- mem_we  out  1  one-cycle write strobe to progmem
- mem_addr  out  ADDR_WIDTH  progmem word address
- mem_wdata  out  32  instruction word
- core_hold  out  1  held high to keep the core in reset
- load_done  out  1  image loaded and verified
- load_error  out  1  load failed
- err_code  out  2  0 none, 1 size, 2 illegal opcode, 3 checksum
- words_loaded  out  ADDR_WIDTH+1  count of words written

Behaviour:
- Reset is synchronous and active-high, on clk.
- Reset values:
  - state = SYNC
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - core_hold = 1
  - load_done = 0, load_error = 0, err_code = 0
  - words_loaded = 0
  - checksum accumulator = 0, byte index = 0
- in_ready is decoded from state:
  - 1 in SYNC, CNT_LO, CNT_HI, DATA, CHK.
  - 0 in WRITE, DONE, ERR.
- Frame format: SYNC_BYTE, N[7:0], N[15:8], then N×4 payload bytes (little-endian per word), then 1 checksum byte.
- Checksum byte = XOR of all payload bytes; it is 8'h00 when N = 0.
- Instruction word field layout: opcode [31:27], dest [26:18], src1 [17:9], src2 [8:0].
- SYNC state: accepted bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE moves to CNT_LO.
- CNT_LO: latch N low byte, go to CNT_HI.
- CNT_HI: latch N high byte, then branch:
  - N > 2**ADDR_WIDTH → ERR, code 1.
  - N = 0 → CHK.
  - Otherwise → DATA.
- DATA:
  - Shift bytes in; byte 0 goes to [7:0], byte 3 to [31:24].
  - XOR each byte into the accumulator.
  - On the 4th byte → WRITE.
- WRITE (exactly 1 cycle):
  - If opcode is in 1..MAX_OPCODE: mem_we = 1, mem_addr = word index, mem_wdata = assembled word, words_loaded increments.
  - Then go to CHK if word index = N−1; otherwise increment word index and go to DATA.
  - If opcode is illegal: no write (mem_we = 0), go to ERR, code 2.
- Latency: 4th byte accepted at edge k → mem_we high in the cycle following edge k. in_ready is 0 during that cycle, so one bubble per word.
- CHK: accept 1 byte. Match → DONE; mismatch → ERR, code 3.
- DONE: load_done = 1, core_hold = 0, in_ready = 0. Sticky until rst.
- ERR: load_error = 1, core_hold = 1, err_code held. Sticky until rst. No further writes.
- mem_addr and mem_wdata hold their last value when mem_we = 0.
- in_valid low in any state: no state change.
- rst mid-frame: abort immediately; all state returns to reset values. Words already written are not erased. The next frame must start with SYNC_BYTE.
- N = 2**ADDR_WIDTH is legal; the last write goes to address 2**ADDR_WIDTH − 1 with no wrap.
- words_loaded is wide enough to hold 2**ADDR_WIDTH.

Test Plan:
- N = 2, words 32'h0A0C0401 (opcode 1) and 32'h90000003 (opcode 18), correct checksum → two mem_we pulses: addr 0 / 0A0C0401, addr 1 / 90000003. Then load_done = 1, core_hold = 0, words_loaded = 2.
- Garbage 8'h00, 8'hFF, then a valid N = 1 frame → garbage ignored, one write at addr 0, load_done = 1.
- N = 1, word 32'h00000000 (opcode 0) → no mem_we; load_error = 1, err_code = 2, core_hold = 1.
- N = 1, legal word, checksum off by one bit → write at addr 0 occurs; then err_code = 3, load_done = 0.
- N = 257 with ADDR_WIDTH = 8 → ERR, err_code = 1 immediately after the count high byte. N = 0 followed by checksum 8'h00 → DONE with words_loaded = 0.
- rst asserted after 2 payload bytes, then a full valid N = 1 frame → clean reload, word at addr 0, load_done = 1. Also toggle in_valid every other cycle; the result is identical.
